// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR with carry-out, zero flag,
// illegal-mode flag and a sideband tag, behind a valid/ready handshake.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          input handshake
//   in_data, in_sha, in_mode   operand, shift amount, operation select
//   in_tag                     opaque tag travelling with the operation
//   out_valid/out_ready        output handshake
//   out_data, out_carry        result and last bit shifted out
//   out_zero, out_illegal      result-is-zero flag, illegal-mode flag
//   out_tag                    tag of the presented result
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_sha,
    input  logic [2:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic                     out_illegal,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SW    = $clog2(WIDTH);
    localparam int LAST  = PIPE_STAGES - 1;
    localparam int BASE  = SW / PIPE_STAGES;
    localparam int EXTRA = SW % PIPE_STAGES;

    localparam logic [2:0] M_SLL = 3'b000;
    localparam logic [2:0] M_SRL = 3'b001;
    localparam logic [2:0] M_SRA = 3'b010;
    localparam logic [2:0] M_ROL = 3'b011;
    localparam logic [2:0] M_ROR = 3'b100;

    // First mux level handled by stage k; earlier stages take the extra level.
    function automatic int lvl_lo(input int k);
        return k * BASE + ((k < EXTRA) ? k : EXTRA);
    endfunction

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[WIDTH-1-i] = d[i];
        end
        return r;
    endfunction

    // Apply mux levels [lo, hi) of a right shift/rotate.
    // Bits leaving the top are replaced by the fill bit unless rotating.
    function automatic logic [WIDTH-1:0] shr_levels(
        input logic [WIDTH-1:0] d,
        input logic [SW-1:0]    sha,
        input logic             rot,
        input logic             fill,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] t;
        int               idx;
        logic             wrap;
        r = d;
        t = d;
        for (int l = 0; l < SW; l++) begin
            if (l >= lo && l < hi && sha[l]) begin
                for (int i = 0; i < WIDTH; i++) begin
                    idx  = (i + (1 << l)) % WIDTH;
                    wrap = (i + (1 << l)) >= WIDTH;
                    t[i] = (wrap && !rot) ? fill : r[idx];
                end
                r = t;
            end
        end
        return r;
    endfunction

    // Operation decode. Left operations are done as right operations on
    // the bit-reversed operand, reversed back in the last stage.
    logic             pre_ill;
    logic             pre_left;
    logic             pre_rot;
    logic             pre_fill;
    logic [SW-1:0]    pre_sha;
    logic [WIDTH-1:0] pre_dat;
    logic             pre_cy;

    always_comb begin
        pre_ill  = 1'b0;
        pre_left = 1'b0;
        pre_rot  = 1'b0;
        pre_fill = 1'b0;
        unique case (1'b1)
            in_mode == M_SLL: pre_left = 1'b1;
            in_mode == M_SRL: pre_left = 1'b0;
            in_mode == M_SRA: pre_fill = in_data[WIDTH-1];
            in_mode == M_ROL: begin
                pre_left = 1'b1;
                pre_rot  = 1'b1;
            end
            in_mode == M_ROR: pre_rot = 1'b1;
            default:          pre_ill = 1'b1;
        endcase
        // Illegal modes pass the operand through unshifted.
        pre_sha = pre_ill ? '0 : in_sha;
        pre_dat = pre_left ? bit_rev(in_data) : in_data;
        // In reversed form the last bit out is always bit s-1.
        pre_cy  = (pre_sha != '0) & pre_dat[pre_sha - SW'(1)];
    end

    // Stage registers.
    logic [PIPE_STAGES-1:0] v;
    logic [WIDTH-1:0]       dat_q  [PIPE_STAGES];
    logic [SW-1:0]          sha_q  [PIPE_STAGES];
    logic                   left_q [PIPE_STAGES];
    logic                   rot_q  [PIPE_STAGES];
    logic                   fill_q [PIPE_STAGES];
    logic                   ill_q  [PIPE_STAGES];
    logic                   cy_q   [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
    logic                   zero_q;

    // Values presented to each stage's register input.
    logic [PIPE_STAGES-1:0] ld;
    logic                   src_v    [PIPE_STAGES];
    logic [WIDTH-1:0]       src_dat  [PIPE_STAGES];
    logic [SW-1:0]          src_sha  [PIPE_STAGES];
    logic                   src_left [PIPE_STAGES];
    logic                   src_rot  [PIPE_STAGES];
    logic                   src_fill [PIPE_STAGES];
    logic                   src_ill  [PIPE_STAGES];
    logic                   src_cy   [PIPE_STAGES];
    logic [TAG_W-1:0]       src_tag  [PIPE_STAGES];
    logic [WIDTH-1:0]       dat_d    [PIPE_STAGES];
    logic                   zero_d;

    // Stage k loads unless it and every later stage are full while the
    // consumer stalls; written flat to avoid a combinational chain on ld.
    always_comb begin
        logic full;
        ld = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < PIPE_STAGES; j++) begin
                full = full & v[j];
            end
            ld[k] = out_ready | ~full;
        end
    end

    always_comb begin
        src_v[0]    = in_valid;
        src_dat[0]  = pre_dat;
        src_sha[0]  = pre_sha;
        src_left[0] = pre_left;
        src_rot[0]  = pre_rot;
        src_fill[0] = pre_fill;
        src_ill[0]  = pre_ill;
        src_cy[0]   = pre_cy;
        src_tag[0]  = in_tag;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            src_v[k]    = v[k-1];
            src_dat[k]  = dat_q[k-1];
            src_sha[k]  = sha_q[k-1];
            src_left[k] = left_q[k-1];
            src_rot[k]  = rot_q[k-1];
            src_fill[k] = fill_q[k-1];
            src_ill[k]  = ill_q[k-1];
            src_cy[k]   = cy_q[k-1];
            src_tag[k]  = tag_q[k-1];
        end
    end

    always_comb begin
        logic [WIDTH-1:0] nd;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            nd = shr_levels(src_dat[k], src_sha[k], src_rot[k],
                            src_fill[k], lvl_lo(k), lvl_lo(k + 1));
            if (k == LAST && src_left[k]) begin
                nd = bit_rev(nd);
            end
            dat_d[k] = nd;
        end
        zero_d = (dat_d[LAST] == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v      <= '0;
            zero_q <= 1'b0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                dat_q[k]  <= '0;
                sha_q[k]  <= '0;
                left_q[k] <= 1'b0;
                rot_q[k]  <= 1'b0;
                fill_q[k] <= 1'b0;
                ill_q[k]  <= 1'b0;
                cy_q[k]   <= 1'b0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (ld[k]) begin
                    v[k]      <= src_v[k];
                    dat_q[k]  <= dat_d[k];
                    sha_q[k]  <= src_sha[k];
                    left_q[k] <= src_left[k];
                    rot_q[k]  <= src_rot[k];
                    fill_q[k] <= src_fill[k];
                    ill_q[k]  <= src_ill[k];
                    cy_q[k]   <= src_cy[k];
                    tag_q[k]  <= src_tag[k];
                end
            end
            if (ld[LAST]) begin
                zero_q <= zero_d;
            end
        end
    end

    assign in_ready    = ld[0];
    assign out_valid   = v[LAST];
    assign out_data    = dat_q[LAST];
    assign out_carry   = cy_q[LAST];
    assign out_zero    = zero_q;
    assign out_illegal = ill_q[LAST];
    assign out_tag     = tag_q[LAST];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed vectors on a
// 2-stage instance, plus a mode/amount sweep on 1- and 5-stage instances.
module tb_pipelined_barrel_shifter;

    localparam int W = 32;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        z;
        logic        il;
        logic [3:0]  t;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t qa[$];
    exp_t qb1[$];
    exp_t qb5[$];

    // DUT A (2 stages)
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic [4:0]  a_in_sha = '0;
    logic [2:0]  a_in_mode = '0;
    logic [3:0]  a_in_tag = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [31:0] a_out_data;
    logic        a_out_carry;
    logic        a_out_zero;
    logic        a_out_illegal;
    logic [3:0]  a_out_tag;

    // Shared stimulus for the sweep instances
    logic        b_in_valid = 1'b0;
    logic [31:0] b_in_data = '0;
    logic [4:0]  b_in_sha = '0;
    logic [2:0]  b_in_mode = '0;
    logic [3:0]  b_in_tag = '0;
    logic        b_out_ready = 1'b1;

    logic        b1_in_ready, b1_out_valid, b1_out_carry;
    logic        b1_out_zero, b1_out_illegal;
    logic [31:0] b1_out_data;
    logic [3:0]  b1_out_tag;
    logic        b5_in_ready, b5_out_valid, b5_out_carry;
    logic        b5_out_zero, b5_out_illegal;
    logic [31:0] b5_out_data;
    logic [3:0]  b5_out_tag;

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(2), .TAG_W(4)) u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_sha(a_in_sha),
        .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_carry(a_out_carry),
        .out_zero(a_out_zero), .out_illegal(a_out_illegal),
        .out_tag(a_out_tag)
    );

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(1), .TAG_W(4)) u_b1 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b1_in_ready),
        .in_data(b_in_data), .in_sha(b_in_sha),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b1_out_valid), .out_ready(b_out_ready),
        .out_data(b1_out_data), .out_carry(b1_out_carry),
        .out_zero(b1_out_zero), .out_illegal(b1_out_illegal),
        .out_tag(b1_out_tag)
    );

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(5), .TAG_W(4)) u_b5 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b5_in_ready),
        .in_data(b_in_data), .in_sha(b_in_sha),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b5_out_valid), .out_ready(b_out_ready),
        .out_data(b5_out_data), .out_carry(b5_out_carry),
        .out_zero(b5_out_zero), .out_illegal(b5_out_illegal),
        .out_tag(b5_out_tag)
    );

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endfunction

    function automatic void check_out(input string nm, input exp_t e,
                                      input logic [31:0] d, input logic c,
                                      input logic z, input logic il,
                                      input logic [3:0] t, input int lat_want);
        chk({nm, "_tag"}, 64'(t), 64'(e.t));
        chk({nm, "_data"}, 64'(d), 64'(e.d));
        chk({nm, "_carry"}, 64'(c), 64'(e.c));
        chk({nm, "_zero"}, 64'(z), 64'(e.z));
        chk({nm, "_illegal"}, 64'(il), 64'(e.il));
        if (lat_want >= 0) begin
            chk({nm, "_latency"}, 64'(cyc - e.acc), 64'(lat_want));
        end
    endfunction

    function automatic void unexpected(input string nm, input logic [3:0] t);
        compared++;
        mismatched++;
        $display("FAIL %s_unexpected: got output tag %0h, want no output", nm, t);
    endfunction

    // Behavioural reference written directly from the bit equations.
    function automatic exp_t model(input logic [2:0] m, input logic [31:0] d,
                                   input logic [4:0] s, input logic [3:0] t);
        exp_t e;
        int   si;
        si = int'(s);
        e.d = d;
        for (int i = 0; i < W; i++) begin
            case (m)
                3'd0: e.d[i] = (i >= si) ? d[i-si] : 1'b0;
                3'd1: e.d[i] = (i + si < W) ? d[i+si] : 1'b0;
                3'd2: e.d[i] = (i + si < W) ? d[i+si] : d[W-1];
                3'd3: e.d[i] = d[(i - si + W) % W];
                3'd4: e.d[i] = d[(i + si) % W];
                default: e.d[i] = d[i];
            endcase
        end
        if (si == 0 || m > 3'd4) e.c = 1'b0;
        else if (m == 3'd0 || m == 3'd3) e.c = d[W-si];
        else e.c = d[si-1];
        e.z = (e.d == 32'd0);
        e.il = (m > 3'd4);
        e.t = t;
        e.acc = 0;
        return e;
    endfunction

    // Output monitors
    exp_t ea, eb1, eb5;

    always @(negedge clk) begin
        if (reset === 1'b0 && a_out_valid === 1'b1 && a_out_ready) begin
            if (qa.size() == 0) unexpected("a", a_out_tag);
            else begin
                ea = qa.pop_front();
                check_out("a", ea, a_out_data, a_out_carry, a_out_zero,
                          a_out_illegal, a_out_tag, -1);
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && b1_out_valid === 1'b1 && b_out_ready) begin
            if (qb1.size() == 0) unexpected("p1", b1_out_tag);
            else begin
                eb1 = qb1.pop_front();
                check_out("p1", eb1, b1_out_data, b1_out_carry, b1_out_zero,
                          b1_out_illegal, b1_out_tag, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && b5_out_valid === 1'b1 && b_out_ready) begin
            if (qb5.size() == 0) unexpected("p5", b5_out_tag);
            else begin
                eb5 = qb5.pop_front();
                check_out("p5", eb5, b5_out_data, b5_out_carry, b5_out_zero,
                          b5_out_illegal, b5_out_tag, 5);
            end
        end
    end

    task automatic drive_a(input logic [2:0] m, input logic [31:0] d,
                           input logic [4:0] s, input logic [3:0] t);
        a_in_valid = 1'b1;
        a_in_mode = m;
        a_in_data = d;
        a_in_sha = s;
        a_in_tag = t;
    endtask

    task automatic accept_a(input logic [31:0] ed, input logic ec,
                            input logic ez, input logic ei, input logic [3:0] t);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (a_in_ready) begin
                acc = 1'b1;
                qa.push_back('{d: ed, c: ec, z: ez, il: ei, t: t, acc: cyc});
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL a_accept_timeout: got in_ready=0 for 50 cycles, want 1 (tag %0h)", t);
        end
        a_in_valid = 1'b0;
    endtask

    task automatic send_a(input logic [2:0] m, input logic [31:0] d,
                          input logic [4:0] s, input logic [3:0] t,
                          input logic [31:0] ed, input logic ec,
                          input logic ez, input logic ei);
        drive_a(m, d, s, t);
        accept_a(ed, ec, ez, ei, t);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb1.size() != 0 || qb5.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({nm, "_drained"}, 64'(qa.size() + qb1.size() + qb5.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, want finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data", 64'(a_out_data), 64'd0);
        chk("rst_out_carry", 64'(a_out_carry), 64'd0);
        chk("rst_out_zero", 64'(a_out_zero), 64'd0);
        chk("rst_out_illegal", 64'(a_out_illegal), 64'd0);
        chk("rst_out_tag", 64'(a_out_tag), 64'd0);
        chk("rst_p1_valid", 64'(b1_out_valid), 64'd0);
        chk("rst_p5_valid", 64'(b5_out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed vectors, back to back, out_ready=1
        send_a(3'd0, 32'h0000_0141, 5'd7,  4'h3, 32'h0000_A080, 0, 0, 0);
        send_a(3'd2, 32'h8000_0000, 5'd4,  4'h1, 32'hF800_0000, 0, 0, 0);
        send_a(3'd1, 32'h8000_0000, 5'd4,  4'h2, 32'h0800_0000, 0, 0, 0);
        send_a(3'd4, 32'h0000_0001, 5'd1,  4'h4, 32'h8000_0000, 1, 0, 0);
        send_a(3'd3, 32'h8000_0000, 5'd1,  4'h5, 32'h0000_0001, 1, 0, 0);
        send_a(3'd0, 32'h0000_0001, 5'd31, 4'h6, 32'h8000_0000, 0, 0, 0);
        send_a(3'd0, 32'h8000_0000, 5'd1,  4'h7, 32'h0000_0000, 1, 1, 0);
        send_a(3'd4, 32'h1234_5678, 5'd31, 4'h8, 32'h2468_ACF0, 0, 0, 0);
        send_a(3'd2, 32'h8000_0001, 5'd31, 4'h9, 32'hFFFF_FFFF, 0, 0, 0);
        send_a(3'd1, 32'h0000_00F0, 5'd0,  4'hA, 32'h0000_00F0, 0, 0, 0);
        send_a(3'd6, 32'h0000_1234, 5'd5,  4'hB, 32'h0000_1234, 0, 0, 1);
        send_a(3'd7, 32'h0000_0000, 5'd3,  4'hC, 32'h0000_0000, 0, 1, 1);
        drain("directed");

        // Backpressure: two operations fill the pipe, the third waits
        a_out_ready = 1'b0;
        send_a(3'd0, 32'h0000_0001, 5'd1, 4'h1, 32'h0000_0002, 0, 0, 0);
        send_a(3'd1, 32'h0000_0100, 5'd4, 4'h2, 32'h0000_0010, 0, 0, 0);
        drive_a(3'd3, 32'hF000_0000, 5'd4, 4'h3);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(a_in_ready), 64'd0);
            chk("bp_out_valid", 64'(a_out_valid), 64'd1);
            chk("bp_out_tag", 64'(a_out_tag), 64'd1);
            chk("bp_out_data", 64'(a_out_data), 64'd2);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        accept_a(32'h0000_000F, 1, 0, 0, 4'h3);
        drain("backpressure");

        // Reset with two operations in flight; input offered during reset
        a_out_ready = 1'b0;
        send_a(3'd0, 32'h0000_00FF, 5'd2, 4'h5, 32'h0000_03FC, 0, 0, 0);
        send_a(3'd1, 32'h0000_00FF, 5'd2, 4'h6, 32'h0000_003F, 1, 0, 0);
        @(negedge clk);
        chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
        chk("pre_rst_in_ready", 64'(a_in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_out_ready = 1'b1;
        qa.delete();
        drive_a(3'd0, 32'h0000_0003, 5'd1, 4'hE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(a_out_valid), 64'd0);
        chk("post_rst_data", 64'(a_out_data), 64'd0);
        chk("post_rst_tag", 64'(a_out_tag), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        send_a(3'd1, 32'h0000_FF00, 5'd8, 4'hD, 32'h0000_00FF, 0, 0, 0);
        drain("post_reset");

        // Sweep on 1- and 5-stage instances, out_ready held at 1
        for (int m = 0; m < 5; m++) begin
            for (int s = 0; s < 32; s++) begin
                b_in_valid = 1'b1;
                b_in_mode = m[2:0];
                b_in_sha = s[4:0];
                b_in_data = $urandom;
                b_in_tag = 4'(m * 32 + s);
                acc = 1'b0;
                for (int k = 0; k < 20 && !acc; k++) begin
                    @(negedge clk);
                    if (b1_in_ready && b5_in_ready) begin
                        acc = 1'b1;
                        e = model(b_in_mode, b_in_data, b_in_sha, b_in_tag);
                        e.acc = cyc;
                        qb1.push_back(e);
                        qb5.push_back(e);
                    end
                    @(posedge clk);
                    #1;
                end
                if (!acc) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sweep_accept_timeout: got in_ready=0, want 1 (mode %0d sha %0d)", m, s);
                end
            end
        end
        b_in_valid = 1'b0;
        drain("sweep");

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit left shifter.
- Supports logical left/right, arithmetic right, rotate left and rotate right.
- Produces carry-out (last bit shifted out) and zero flags.
- Accepts one operation per cycle under a valid/ready handshake with full backpressure; a sideband tag travels with each operation. Sits between the ALU operand mux and the writeback register.

Parameters:
- WIDTH, 32: data width; power of two, at least 8.
- PIPE_STAGES, 2: register stages, i.e. latency in cycles. Legal range 1..log2(WIDTH). The log2(WIDTH) mux levels are split across stages as evenly as possible, with earlier stages taking the extra level.
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operation present
- in_ready  out  1  shifter can accept the input this cycle
- in_data  in  WIDTH  operand
- in_sha  in  log2(WIDTH)  shift amount
- in_mode  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 illegal
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_carry  out  1  last bit shifted out
- out_zero  out  1  out_data equals zero
- out_illegal  out  1  operation had an illegal mode
- out_tag  out  TAG_W  tag of this result

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a clk edge with reset=1, every stage valid bit clears, out_valid=0, and out_data, out_carry, out_zero, out_illegal, out_tag all read 0.
- in_ready may be 1 during reset. Any input offered during reset is dropped.
- Transfers:
  - Input transfer: in_valid and in_ready are both 1 on a clk edge.
  - Output transfer: out_valid and out_ready are both 1 on a clk edge.
- Stage k (0..PIPE_STAGES-1) holds valid v[k] plus partial data, remaining shift amount, mode, tag, carry and illegal bit.
- Stage k loads when !v[k] or stage k+1 loads. The last stage loads when !v[last] or out_ready.
- in_ready = stage 0 loads. This is a combinational path from out_ready, which is allowed.
- Latency: an operation accepted at edge N is visible on out_* after edge N+PIPE_STAGES when there are no stalls.
- Throughput is one operation per cycle with out_ready held at 1.
- Stall behaviour:
  - While out_valid=1 and out_ready=0, all out_* hold stable.
  - Held operations are never dropped, duplicated or reordered.
  - Once the pipeline is full, at most PIPE_STAGES operations are buffered.
- Simultaneous events: if the last stage drains and a new input is accepted on the same edge, the pipeline shifts by one and no bubble is inserted.
- Arithmetic, result bit i (s = in_sha, W = WIDTH):
  - SLL: in[i-s] if i>=s, else 0.
  - SRL: in[i+s] if i+s<W, else 0.
  - SRA: same as SRL but the fill is in[W-1].
  - ROL: in[(i-s) mod W].
  - ROR: in[(i+s) mod W].
- Carry:
  - s=0 gives carry 0 for every mode.
  - SLL/ROL: carry = in[W-s].
  - SRL/SRA/ROR: carry = in[s-1].
- out_zero is computed in the last stage from the final result.
- Illegal mode: result = in_data unshifted, carry 0, out_illegal=1, tag preserved. out_illegal is 0 for legal modes.
- Maximum shift s=W-1:
  - SLL gives in[0] at the MSB.
  - SRA of a negative operand gives all ones.
  - ROR gives the same result as ROL by 1.
- Reset mid-operation: every in-flight operation is discarded and no partial result is ever presented. The first output after reset comes from the first input accepted after reset deasserts.

Test Plan:
- WIDTH=32, PIPE_STAGES=2, out_ready=1; SLL in_data=321 (0x141), sha=7, tag=3 -> 2 cycles later out_data=0x0000A080, carry=0, zero=0, tag=3.
- SRA 0x80000000 sha=4 -> 0xF8000000, carry=0. SRL of the same operand -> 0x08000000.
- ROR 0x00000001 sha=1 -> 0x80000000, carry=1. ROL 0x80000000 sha=1 -> 0x00000001, carry=1. SLL 0x00000001 sha=31 -> 0x80000000, carry=0. SLL 0x80000000 sha=1 -> out_data=0, zero=1, carry=1.
- Backpressure: out_ready=0, offer tags 1,2,3 on consecutive cycles -> tags 1 and 2 accepted, in_ready=0 for tag 3 and out_* stable. Raise out_ready -> outputs in order 1,2,3 with no loss and no duplicates.
- Illegal mode 110, in_data=0x1234, sha=5 -> out_data=0x1234, carry=0, illegal=1. Then assert reset for 1 cycle with 2 operations in flight -> out_valid=0 next cycle and neither operation ever appears.
- Sweep PIPE_STAGES=1 and 5, all 5 legal modes × all 32 shift amounts × random data, compared against a behavioural model -> full match, latency equals PIPE_STAGES.
